nucore_fetch: RTL and testbench
===============================

Name: nucore_fetch

Overview:
Instruction fetch stage of NuCore; sits directly upstream of the 39-bit instruction pipeline register that feeds the instruction decoder.
- Replaces the fixed program counter / instruction queue pair with a loadable program memory, sequential program loading, a start/halt sequencer and stall support.
- Emits one 39-bit instruction per cycle, or a NOP bubble when it has nothing to issue.

Parameters:
- DEPTH, 64, program memory depth in words; must be a power of two.
- AW, 6, address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  program word offered.
- load_ready  out  1  fetch stage accepts a program word this cycle.
- load_data  in  39  program word.
- load_last  in  1  qualifies the final word of the program.
- start  in  1  begin execution from address 0.
- stall  in  1  hold pc and all outputs this cycle.
- inst_out  out  39  instruction to the pipeline register.
- inst_valid  out  1  inst_out holds a real instruction.
- pc  out  AW  address of the next word to fetch.
- halted  out  1  program finished.
- loaded  out  1  a complete program is resident.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; pc=0; wr_ptr=0; prog_len=0.
  - loaded=0; halted=0; inst_valid=0; inst_out=NOP_WORD (all zeros).
  - Memory contents are not cleared.
- States: IDLE, LOAD, RUN, HALT.
- load_ready=1 in IDLE, LOAD and HALT; load_ready=0 in RUN.
- Word acceptance: a word is accepted when load_valid and load_ready are both high.
  - Write: mem[wr_ptr] <= load_data; wr_ptr increments.
  - State moves to LOAD and loaded is cleared.
- End of load: on an accepted word with load_last=1, or on an accepted word at wr_ptr=DEPTH-1 (forced last):
  - prog_len <= wr_ptr+1 (AW+1 bits, so 64 is representable).
  - wr_ptr <= 0; loaded <= 1; state <= IDLE.
- start in IDLE or HALT with loaded=1 and no accepted word that cycle:
  - pc <= 0; halted <= 0; state <= RUN.
- start is ignored in these cases:
  - loaded=0;
  - in LOAD;
  - a word is accepted in the same cycle (load wins).
- RUN, with stall=0, each cycle:
  - If mem[pc]==HALT_WORD: inst_out <= NOP_WORD; inst_valid <= 0; halted <= 1; state <= HALT. HALT_WORD is never issued.
  - Otherwise: inst_out <= mem[pc]; inst_valid <= 1; pc <= pc+1.
  - If pc+1==prog_len: the word is still issued, then next cycle state=HALT, halted=1, inst_valid=0, inst_out=NOP_WORD.
- RUN with stall=1: pc, inst_out and inst_valid hold their values; memory is not read.
- stall has no effect outside RUN.
- Latency: the first instruction (mem[0]) appears on inst_out the cycle after the start cycle. Thereafter one word per unstalled cycle.
- HALT: inst_valid=0 and inst_out=NOP_WORD; pc holds its last value.
- pc never exceeds prog_len; no wrap-around is possible.
- Reset mid-RUN or mid-LOAD: takes effect immediately. loaded=0 and the program must be reloaded.

Optional Feature:
- Macro: NUCORE_FETCH_STEP_EN.
- Defined:
  - Adds input port step (1 bit). An internal register detects the rising edge of step.
  - In RUN, a fetch occurs only in a cycle with a step rising edge and stall=0, so exactly one instruction is issued per press.
  - inst_valid is a one-cycle pulse; between steps inst_out=NOP_WORD and inst_valid=0.
  - Halt detection is unchanged but is evaluated only on step edges.
- Undefined: no step port; RUN is free-running as described above.

Decomposition:
- Package nucore_pkg:
  - INST_W=39, NOP_WORD=39'h0, HALT_WORD=39'h7F_FFFF_FFFF;
  - fetch_state_t enum (IDLE, LOAD, RUN, HALT).
- Sub-module nucore_prog_mem:
  - DEPTH x INST_W array;
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata);
  - no reset.

Test Plan:
- Load 3 words (A1, A2, A3; last on A3), then pulse start → inst_out = A1, A2, A3 on consecutive cycles with inst_valid=1; next cycle halted=1, inst_valid=0, inst_out=0, pc=3.
- Load 4 words with HALT_WORD at address 2 → issue mem[0], mem[1]; halted=1; HALT_WORD never appears with inst_valid=1; pc=2.
- Assert stall for 3 cycles after the second issue → inst_out holds mem[1] and pc=2 for 3 cycles; then mem[2] is issued.
- Load 64 words with load_last never asserted → forced last at address 63; loaded=1; run issues 64 words, then halts with pc=64 mod 64=0 and halted=1.
- start with loaded=0 → stays IDLE with inst_valid=0. start together with an accepted word in IDLE → the word is written and start is ignored.
- Assert reset mid-RUN after 2 issues → outputs clear immediately; loaded=0; a subsequent start is ignored until a reload.
- With NUCORE_FETCH_STEP_EN: hold step high for 5 cycles → exactly one instruction issued; 3 separate pulses → 3 issues.

Source files
------------

// File: rtl/nucore_pkg.sv
// nucore_pkg: shared types and constants for the NuCore fetch stage.
//   INST_W        instruction word width
//   NOP_WORD      bubble presented when nothing is issued
//   HALT_WORD     sentinel that stops execution; never issued itself
//   fetch_state_t fetch sequencer states
package nucore_pkg;

  localparam int INST_W = 39;

  localparam logic [INST_W-1:0] NOP_WORD  = '0;
  localparam logic [INST_W-1:0] HALT_WORD = 39'h7F_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/nucore_prog_mem.sv
// nucore_prog_mem: DEPTH x INST_W program store, no reset.
//   clk    write clock (rising edge)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  asynchronous read address
//   rdata  asynchronous read data
module nucore_prog_mem
  import nucore_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/nucore_fetch.sv
// nucore_fetch: NuCore instruction fetch stage. A program is streamed in
// through the load port, then start runs it from address 0, issuing one
// 39-bit instruction per unstalled cycle (NOP bubble otherwise) until the
// HALT_WORD sentinel or the end of the program is reached.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   load_valid/ready    program word handshake; load_data is the word,
//   load_data/last      load_last marks the final word of the program
//   start               begin execution from address 0
//   stall               freeze pc and outputs while running
//   step                (NUCORE_FETCH_STEP_EN only) single-step input
//   inst_out/inst_valid instruction to the pipeline register
//   pc                  address of the next word to fetch
//   halted, loaded      program finished / complete program resident
//
// Optional feature macro: NUCORE_FETCH_STEP_EN. When defined, a step input
// is added and RUN fetches only on a rising edge of step.
module nucore_fetch
  import nucore_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic              stall,
`ifdef NUCORE_FETCH_STEP_EN
  input  logic              step,
`endif
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [AW-1:0]     pc,
  output logic              halted,
  output logic              loaded
);

  localparam logic [AW:0]   PC_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH-1);

  fetch_state_t      state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  // pc and prog_len carry one extra bit so a full DEPTH-word program
  // can be described; the pc port shows only the low AW bits.
  logic [AW:0]       prog_len_q, prog_len_d;
  logic [AW:0]       pc_q, pc_d;
  logic              loaded_q, loaded_d;
  logic              halted_q, halted_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] mem_rdata;

  logic load_acc;
  logic load_end;
  logic start_ok;
  logic fetch_en;
  logic run_idle;
  logic at_end;

  nucore_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (load_acc),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (pc_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign load_acc = load_valid & load_ready;
  // The final address always ends the load, even without load_last.
  assign load_end = load_acc & (load_last | (wr_ptr_q == LAST_ADR));
  // A word accepted in the same cycle takes priority over start.
  assign start_ok = start & loaded_q & ~load_acc &
                    ((state_q == IDLE) | (state_q == HALT));
  // Either the program ran off its end or the sentinel was reached.
  assign at_end   = (pc_q == prog_len_q) | (mem_rdata == HALT_WORD);

`ifdef NUCORE_FETCH_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = step & ~step_q;
  assign fetch_en  = (state_q == RUN) & ~stall & step_rise;
  // Unstalled RUN cycles without a step edge present a bubble, so each
  // press yields a single-cycle inst_valid pulse.
  assign run_idle  = (state_q == RUN) & ~stall & ~step_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end
`else
  assign fetch_en = (state_q == RUN) & ~stall;
  assign run_idle = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: begin
        if (load_acc)      state_d = load_end ? IDLE : LOAD;
        else if (start_ok) state_d = RUN;
      end
      LOAD: begin
        if (load_acc) state_d = load_end ? IDLE : LOAD;
      end
      RUN: begin
        if (fetch_en && at_end) state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready = (state_q != RUN);
  end

  assign inst_out   = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q[AW-1:0];
  assign halted     = halted_q;
  assign loaded     = loaded_q;

  // Datapath next-state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    pc_d         = pc_q;
    loaded_d     = loaded_q;
    halted_d     = halted_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;

    if (load_acc) begin
      loaded_d = 1'b0;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (load_end) begin
        prog_len_d = {1'b0, wr_ptr_q} + PC_ONE;
        wr_ptr_d   = '0;
        loaded_d   = 1'b1;
      end
    end

    if (start_ok) begin
      pc_d     = '0;
      halted_d = 1'b0;
    end

    if (fetch_en) begin
      if (at_end) begin
        inst_d       = NOP_WORD;
        inst_valid_d = 1'b0;
        halted_d     = 1'b1;
      end else begin
        inst_d       = mem_rdata;
        inst_valid_d = 1'b1;
        pc_d         = pc_q + PC_ONE;
      end
    end else if (run_idle) begin
      inst_d       = NOP_WORD;
      inst_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      pc_q         <= '0;
      loaded_q     <= 1'b0;
      halted_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_WORD;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      pc_q         <= pc_d;
      loaded_q     <= loaded_d;
      halted_q     <= halted_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
    end
  end

endmodule

// File: tb/tb_nucore_fetch.sv
// Scoreboard bench for nucore_fetch: stimulus pushes expected issued words
// into a queue; a negedge monitor pops and compares on every new issue.
module tb_nucore_fetch;
  import nucore_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [INST_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic [AW-1:0]     pc;
  logic              halted;
  logic              loaded;
`ifdef NUCORE_FETCH_STEP_EN
  logic              step = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [INST_W-1:0] expq[$];
  logic stall_at_edge = 1'b0;

  nucore_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .start      (start),
    .stall      (stall),
`ifdef NUCORE_FETCH_STEP_EN
    .step       (step),
`endif
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .pc         (pc),
    .halted     (halted),
    .loaded     (loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Outputs update on an edge only when stall was low at that edge.
  always @(posedge clk) stall_at_edge <= stall;

  always @(negedge clk) begin
    if (!reset && inst_valid && !stall_at_edge) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual=%0h expected=none", inst_out);
      end else begin
        chk("issue", {25'd0, inst_out}, {25'd0, expq.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [INST_W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk("halt_reached", halted, 1);
    chk("halt_valid", inst_valid, 0);
    chk("halt_inst", inst_out, 0);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_ready", load_ready, 1);

`ifndef NUCORE_FETCH_STEP_EN
    // start with nothing loaded is ignored
    do_start();
    tick();
    chk("noprog_valid", inst_valid, 0);
    chk("noprog_ready", load_ready, 1);

    // three-word program, natural end
    load_word(39'h11_1111_1111, 1'b0);
    chk("loading_loaded", loaded, 0);
    load_word(39'h22_2222_2222, 1'b0);
    load_word(39'h33_3333_3333, 1'b1);
    chk("p1_loaded", loaded, 1);
    expq.push_back(39'h11_1111_1111);
    expq.push_back(39'h22_2222_2222);
    expq.push_back(39'h33_3333_3333);
    do_start();
    chk("p1_start_halted", halted, 0);
    tick();
    chk("p1_first_valid", inst_valid, 1);
    chk("p1_first_inst", inst_out, 39'h11_1111_1111);
    run_to_halt(10);
    chk("p1_pc", pc, 3);

    // HALT_WORD at address 2
    load_word(39'h0A_0000_0001, 1'b0);
    load_word(39'h0A_0000_0002, 1'b0);
    load_word(HALT_WORD, 1'b0);
    load_word(39'h0A_0000_0004, 1'b1);
    expq.push_back(39'h0A_0000_0001);
    expq.push_back(39'h0A_0000_0002);
    do_start();
    run_to_halt(10);
    chk("p2_pc", pc, 2);

    // stall for three cycles after the second issue
    load_word(39'h05_0000_0000, 1'b0);
    load_word(39'h05_0000_0001, 1'b0);
    load_word(39'h05_0000_0002, 1'b0);
    load_word(39'h05_0000_0003, 1'b1);
    for (int i = 0; i < 4; i++) expq.push_back(39'h05_0000_0000 + 39'(i));
    do_start();
    tick();
    tick();
    chk("p3_pre_inst", inst_out, 39'h05_0000_0001);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p3_stall_inst", inst_out, 39'h05_0000_0001);
      chk("p3_stall_pc", pc, 2);
      chk("p3_stall_valid", inst_valid, 1);
    end
    stall = 1'b0;
    tick();
    chk("p3_resume_inst", inst_out, 39'h05_0000_0002);
    run_to_halt(10);
    chk("p3_pc", pc, 4);

    // 64 words, forced last at address 63
    for (int i = 0; i < 64; i++) begin
      load_word(39'h40_0000_0000 + 39'(i), 1'b0);
      expq.push_back(39'h40_0000_0000 + 39'(i));
    end
    chk("p4_loaded", loaded, 1);
    chk("p4_ready", load_ready, 1);
    do_start();
    run_to_halt(80);
    chk("p4_pc", pc, 0);

    // start together with an accepted word: load wins
    load_word(39'h06_0000_00AA, 1'b0);
    load_word(39'h06_0000_00BB, 1'b1);
    load_valid = 1'b1;
    load_data  = 39'h07_0000_0001;
    start      = 1'b1;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    chk("p5_loaded_cleared", loaded, 0);
    chk("p5_not_run", load_ready, 1);
    load_word(39'h07_0000_0002, 1'b1);
    expq.push_back(39'h07_0000_0001);
    expq.push_back(39'h07_0000_0002);
    do_start();
    run_to_halt(10);
    chk("p5_pc", pc, 2);

    // reset mid-RUN after two issues
    for (int i = 0; i < 4; i++) load_word(39'h08_0000_0000 + 39'(i), i == 3);
    expq.push_back(39'h08_0000_0000);
    expq.push_back(39'h08_0000_0001);
    do_start();
    tick();
    tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("p6_rst_valid", inst_valid, 0);
    chk("p6_rst_inst", inst_out, 0);
    chk("p6_rst_pc", pc, 0);
    chk("p6_rst_loaded", loaded, 0);
    chk("p6_rst_ready", load_ready, 1);
    chk("p6_queue", expq.size(), 0);
    tick();
    reset = 1'b0;
    do_start();
    tick();
    tick();
    chk("p6_nostart_valid", inst_valid, 0);
    chk("p6_nostart_ready", load_ready, 1);
`else
    // step mode: held step gives one issue, separate pulses one each
    for (int i = 0; i < 6; i++) load_word(39'h09_0000_0000 + 39'(i), i == 5);
    for (int i = 0; i < 4; i++) expq.push_back(39'h09_0000_0000 + 39'(i));
    do_start();
    tick();
    chk("s_idle_valid", inst_valid, 0);
    step = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    step = 1'b0;
    tick();
    chk("s_hold_remaining", expq.size(), 3);
    chk("s_hold_pc", pc, 1);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      chk("s_between_valid", inst_valid, 0);
      chk("s_between_inst", inst_out, 0);
    end
    chk("s_queue_drained", expq.size(), 0);
    chk("s_pc", pc, 4);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
